face_blink_gen: RTL and testbench
=================================

# face_blink_gen

Pixel source for the animation controller's SMILE face. The LCD driver presents a pixel address (x, y); this block returns the RGB565 colour of a face with two eyes and a mouth. The eyes blink on a frame-synchronous state machine. Its output feeds the controller's `ram_data` mux, so it sits directly upstream of the LCD driver.

## Interface
- `LCD_W`, default 132: screen width in pixels.
- `LCD_H`, default 162: screen height in pixels.
- `BG_COLOR`, default 16'h2935: background colour (RGB565).
- `FG_COLOR`, default 16'hFFFF: eye and mouth colour.
- `HOLD_FRAMES`, default 60: frames spent fully open before an automatic blink; range 1..255.
- `STEP_FRAMES`, default 2: frames per lid step; range 1..15.
- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `blink_req` input 1: single-cycle request for an immediate blink.
- `ram_addr_x` input 8: pixel column from the LCD driver.
- `ram_addr_y` input 8: pixel row from the LCD driver.
- `ram_data` output 16: registered pixel colour.
- `frame_tick` output 1: one-cycle pulse at each frame start.
- `phase` output 2: blink state, encoded OPEN=0, CLOSING=1, CLOSED=2, OPENING=3.
- `busy` output 1: high whenever `phase` is not OPEN.

## Operation
- **Frame detection**
  - `prev_x`/`prev_y` hold the previous cycle's address. They reset to (LCD_W-1, LCD_H-1).
  - Frame start: the current address is (0,0) and the previous address was not (0,0).
  - `frame_tick` is registered, so it is high for the cycle after detection.
  - State and counters change only on a frame tick, so a frame is never rendered with mixed lid levels.
- **Lid level** `lid`: 3 bits, 0..4, where 0 is fully open.
- **Frame counters**: `hold_cnt` is 8 bits and `step_cnt` is 4 bits. Both count frame ticks only.
- **Request latch** `pend`:
  - Set by `blink_req` only while in OPEN.
  - Requests arriving in any other state are dropped, not queued.
  - Cleared on leaving OPEN.
  - If `blink_req` and a tick arrive in the same cycle, the request is honoured at that tick.
- **FSM transitions, evaluated on tick only**
  - OPEN:
    - If `pend`, or `hold_cnt` == HOLD_FRAMES-1: go to CLOSING, clear `step_cnt`.
    - Otherwise increment `hold_cnt`.
  - CLOSING:
    - If `step_cnt` == STEP_FRAMES-1: clear `step_cnt` and increment `lid`.
    - If `lid` becomes 4, go to CLOSED.
    - Otherwise increment `step_cnt`.
  - CLOSED: after STEP_FRAMES ticks, go to OPENING and clear `step_cnt`.
  - OPENING:
    - Every STEP_FRAMES ticks, decrement `lid`.
    - When `lid` reaches 0, go to OPEN and clear `hold_cnt`.
- **Geometry, inclusive bounds**
  - Eye columns: left eye 36..51, right eye 80..95.
  - Eye rows for `lid` 0..3: (50+2·lid) .. (65−2·lid).
  - Eye rows for `lid` 4: 57..58 (closed-eye line).
  - Mouth: x 46..85, y 100..103, always drawn.
  - A pixel inside any eye or the mouth gets FG_COLOR. All other pixels get BG_COLOR.
  - Addresses with x ≥ LCD_W or y ≥ LCD_H get BG_COLOR.
- **Width rules**
  - All compares are unsigned 8-bit.
  - `lid` arithmetic saturates at 0 and 4.

## Timing
- **Reset values**
  - `ram_data` = BG_COLOR, `frame_tick` = 0, `phase` = 0, `busy` = 0.
  - `lid` = 0, all counters = 0, `pend` = 0.
- **Latency**
  - `ram_data` reflects the address sampled on the previous edge: 1-cycle latency.
  - The LCD driver holds each address for at least 2 cycles per 16-bit SPI word.
- **Tick-to-state latency**
  - `phase`, `busy` and `lid` update on the same edge on which the registered `frame_tick` goes high.
  - Pixels computed from that cycle onward use the new `lid`.
- **Reset mid-blink** returns immediately to OPEN with `lid` = 0. The next frame renders with eyes open.
- **Address held at (0,0)** for many cycles produces exactly one tick.
- **Period check**: a full auto-blink cycle is HOLD_FRAMES + 4·STEP_FRAMES + STEP_FRAMES + 4·STEP_FRAMES frames. With defaults that is 60 + 8 + 2 + 8 = 78.

## Test plan
- **Reset and pixel colours**: assert reset, then scan one frame.
  - (40,55) reads 16'hFFFF one cycle later.
  - (10,10) reads 16'h2935.
  - (60,101) reads 16'hFFFF.
  - (200,10) reads 16'h2935.
  - `phase` = 0.
- **Frame ticks**: raster-scan 3 frames. Exactly 3 one-cycle `frame_tick` pulses, the first on the first (0,0) after reset.
- **Requested blink**: with HOLD_FRAMES=60 and STEP_FRAMES=2, pulse `blink_req` mid-frame 5.
  - CLOSING is entered at the next tick.
  - After 8 more ticks `phase` = 2. (40,51) and (40,57) read BG and FG respectively.
  - Back to OPEN 10 ticks later.
- **Auto blink**: with no requests, CLOSING is entered at tick 60. `busy` stays high for exactly 18 frames.
- **Dropped request**: pulse `blink_req` while in CLOSED. No extra blink follows; OPEN holds for a full 60 frames.
- **Reset mid-blink**: assert `rst` during OPENING with `lid` = 2.
  - Next cycle: `phase` = 0 and `busy` = 0.
  - After the next frame, (40,50) reads FG.

Source files
------------

// File: rtl/face_blink_gen.sv
// face_blink_gen
// Pixel source for the SMILE face. It returns the RGB565 colour for the pixel
// address presented by the LCD driver. Two eyes blink on a frame-synchronous
// state machine, and a mouth is always drawn.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   blink_req       single-cycle request for an immediate blink
//   ram_addr_x/y    pixel column / row from the LCD driver
//   ram_data        registered pixel colour (1-cycle latency)
//   frame_tick      one-cycle pulse, the cycle after frame start is detected
//   phase           blink state (OPEN=0, CLOSING=1, CLOSED=2, OPENING=3)
//   busy            high whenever phase is not OPEN
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_OPEN    | eyes fully open, counting hold frames, latching requests
// S_CLOSING | lid steps 0 -> 4, one step every STEP_FRAMES ticks
// S_CLOSED  | lid at 4 for STEP_FRAMES ticks
// S_OPENING | lid steps 4 -> 0, one step every STEP_FRAMES ticks
module face_blink_gen #(
    parameter int          LCD_W       = 132,
    parameter int          LCD_H       = 162,
    parameter logic [15:0] BG_COLOR    = 16'h2935,
    parameter logic [15:0] FG_COLOR    = 16'hFFFF,
    parameter int          HOLD_FRAMES = 60,
    parameter int          STEP_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        blink_req,
    input  logic [7:0]  ram_addr_x,
    input  logic [7:0]  ram_addr_y,
    output logic [15:0] ram_data,
    output logic        frame_tick,
    output logic [1:0]  phase,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_OPEN    = 2'd0,
        S_CLOSING = 2'd1,
        S_CLOSED  = 2'd2,
        S_OPENING = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] STEP_LAST  = 4'(STEP_FRAMES - 1);
    localparam logic [7:0] PREV_X_RST = 8'(LCD_W - 1);
    localparam logic [7:0] PREV_Y_RST = 8'(LCD_H - 1);
    // 9 bits so that a full 256-pixel dimension does not wrap to zero
    localparam logic [8:0] LCD_W9     = 9'(LCD_W);
    localparam logic [8:0] LCD_H9     = 9'(LCD_H);

    state_t      state_q;
    logic [2:0]  lid_q;
    logic [7:0]  hold_q;
    logic [3:0]  step_q;
    logic        pend_q;
    logic        busy_q;
    logic        frame_tick_q;
    logic [15:0] ram_data_q;
    logic [7:0]  prev_x_q;
    logic [7:0]  prev_y_q;

    logic [2:0]  lid_up_d;
    logic [2:0]  lid_dn_d;
    logic        frame_det;
    logic [3:0]  lid_x2;
    logic [7:0]  eye_top;
    logic [7:0]  eye_bot;
    logic        in_cols;
    logic        in_rows;
    logic        in_mouth;
    logic        in_screen;
    logic        pix_fg;

    // Saturating lid steps
    assign lid_up_d = (lid_q >= 3'd4) ? 3'd4 : lid_q + 3'd1;
    assign lid_dn_d = (lid_q == 3'd0) ? 3'd0 : lid_q - 3'd1;

    // Only the first cycle at (0,0) counts, so a held origin gives one tick
    assign frame_det = (ram_addr_x == 8'd0) && (ram_addr_y == 8'd0) &&
                       !((prev_x_q == 8'd0) && (prev_y_q == 8'd0));

    always_comb begin
        lid_x2 = {lid_q, 1'b0};
        if (lid_q >= 3'd4) begin
            // closed-eye line
            eye_top = 8'd57;
            eye_bot = 8'd58;
        end else begin
            eye_top = 8'd50 + {4'd0, lid_x2};
            eye_bot = 8'd65 - {4'd0, lid_x2};
        end
        in_cols   = ((ram_addr_x >= 8'd36) && (ram_addr_x <= 8'd51)) ||
                    ((ram_addr_x >= 8'd80) && (ram_addr_x <= 8'd95));
        in_rows   = (ram_addr_y >= eye_top) && (ram_addr_y <= eye_bot);
        in_mouth  = (ram_addr_x >= 8'd46) && (ram_addr_x <= 8'd85) &&
                    (ram_addr_y >= 8'd100) && (ram_addr_y <= 8'd103);
        in_screen = ({1'b0, ram_addr_x} < LCD_W9) && ({1'b0, ram_addr_y} < LCD_H9);
        pix_fg    = in_screen && ((in_cols && in_rows) || in_mouth);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OPEN;
            lid_q        <= 3'd0;
            hold_q       <= 8'd0;
            step_q       <= 4'd0;
            pend_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_tick_q <= 1'b0;
            ram_data_q   <= BG_COLOR;
            prev_x_q     <= PREV_X_RST;
            prev_y_q     <= PREV_Y_RST;
        end else begin
            prev_x_q     <= ram_addr_x;
            prev_y_q     <= ram_addr_y;
            frame_tick_q <= frame_det;
            ram_data_q   <= pix_fg ? FG_COLOR : BG_COLOR;

            // Set before the transition logic so that leaving OPEN on this
            // same edge still wins and clears the latch.
            if ((state_q == S_OPEN) && blink_req) begin
                pend_q <= 1'b1;
            end

            if (frame_det) begin
                case (state_q)
                    S_OPEN: begin
                        // blink_req on the tick cycle is honoured immediately
                        if (pend_q || blink_req || (hold_q == HOLD_LAST)) begin
                            state_q <= S_CLOSING;
                            busy_q  <= 1'b1;
                            step_q  <= 4'd0;
                            pend_q  <= 1'b0;
                        end else begin
                            hold_q <= hold_q + 8'd1;
                        end
                    end
                    S_CLOSING: begin
                        if (step_q == STEP_LAST) begin
                            step_q <= 4'd0;
                            lid_q  <= lid_up_d;
                            if (lid_up_d == 3'd4) begin
                                state_q <= S_CLOSED;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                    S_CLOSED: begin
                        if (step_q == STEP_LAST) begin
                            state_q <= S_OPENING;
                            step_q  <= 4'd0;
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                    S_OPENING: begin
                        if (step_q == STEP_LAST) begin
                            step_q <= 4'd0;
                            lid_q  <= lid_dn_d;
                            if (lid_dn_d == 3'd0) begin
                                state_q <= S_OPEN;
                                busy_q  <= 1'b0;
                                hold_q  <= 8'd0;
                            end
                        end else begin
                            step_q <= step_q + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign ram_data   = ram_data_q;
    assign frame_tick = frame_tick_q;
    assign phase      = state_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_face_blink_gen.sv
// Testbench for face_blink_gen: table-driven pixel vectors, directed blink
// sequences and a randomized run, all checked against a frame-level model.
module tb_face_blink_gen;

    localparam int          W    = 132;
    localparam int          H    = 162;
    localparam logic [15:0] BG   = 16'h2935;
    localparam logic [15:0] FG   = 16'hFFFF;
    localparam int          HOLD = 60;
    localparam int          STEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        blink_req;
    logic [7:0]  ax;
    logic [7:0]  ay;
    logic [15:0] ram_data;
    logic        frame_tick;
    logic [1:0]  phase;
    logic        busy;

    always #5 clk = ~clk;

    face_blink_gen #(
        .LCD_W(W), .LCD_H(H), .BG_COLOR(BG), .FG_COLOR(FG),
        .HOLD_FRAMES(HOLD), .STEP_FRAMES(STEP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .blink_req(blink_req),
        .ram_addr_x(ax),
        .ram_addr_y(ay),
        .ram_data(ram_data),
        .frame_tick(frame_tick),
        .phase(phase),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Frame-level model: either open (m_n ticks since eyes opened) or
    // blinking (m_k ticks since the blink started).
    bit          m_blink;
    bit          m_pend;
    int          m_n;
    int          m_k;
    int          m_px;
    int          m_py;
    logic [15:0] e_data;
    bit          e_tick;

    logic [15:0] last_data;
    int          tick_cnt;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] exp;
    } vec_t;
    vec_t vt[14];

    function automatic int lid_of();
        if (!m_blink)           return 0;
        if (m_k < 4 * STEP)     return m_k / STEP;
        if (m_k < 5 * STEP)     return 4;
        return 4 - (m_k - 5 * STEP) / STEP;
    endfunction

    function automatic int phase_of();
        if (!m_blink)           return 0;
        if (m_k < 4 * STEP)     return 1;
        if (m_k < 5 * STEP)     return 2;
        return 3;
    endfunction

    function automatic logic [15:0] colour(input int x, input int y, input int lid);
        int top;
        int bot;
        bit fg;
        if (x >= W || y >= H) return BG;
        if (lid == 4) begin
            top = 57;
            bot = 58;
        end else begin
            top = 50 + 2 * lid;
            bot = 65 - 2 * lid;
        end
        fg = (((x >= 36 && x <= 51) || (x >= 80 && x <= 95)) && y >= top && y <= bot) ||
             (x >= 46 && x <= 85 && y >= 100 && y <= 103);
        return fg ? FG : BG;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge(input int x, input int y, input bit req, input bit r);
        bit det;
        if (r) begin
            e_data  = BG;
            e_tick  = 1'b0;
            m_blink = 1'b0;
            m_pend  = 1'b0;
            m_n     = 0;
            m_k     = 0;
            m_px    = W - 1;
            m_py    = H - 1;
        end else begin
            e_data = colour(x, y, lid_of());
            det    = (x == 0 && y == 0) && !(m_px == 0 && m_py == 0);
            e_tick = det;
            if (!m_blink && req) m_pend = 1'b1;
            if (det) begin
                if (!m_blink) begin
                    m_n++;
                    if (m_pend || m_n == HOLD) begin
                        m_blink = 1'b1;
                        m_k     = 0;
                        m_pend  = 1'b0;
                    end
                end else begin
                    m_k++;
                    if (m_k == 9 * STEP) begin
                        m_blink = 1'b0;
                        m_n     = 0;
                    end
                end
            end
            m_px = x;
            m_py = y;
        end
    endtask

    task automatic step(input int x, input int y, input bit req, input bit r);
        ax        = x[7:0];
        ay        = y[7:0];
        blink_req = req;
        rst       = r;
        @(posedge clk);
        model_edge(x, y, req, r);
        @(negedge clk);
        check("ram_data",   int'(ram_data),   int'(e_data));
        check("frame_tick", int'(frame_tick), int'(e_tick));
        check("phase",      int'(phase),      phase_of());
        check("busy",       int'(busy),       int'(m_blink));
        last_data = ram_data;
        if (frame_tick) tick_cnt++;
    endtask

    task automatic frame(input int px, input int py, input bit req);
        step(0, 0, 1'b0, 1'b0);
        step(0, 0, 1'b0, 1'b0);
        step(px, py, req, 1'b0);
        step(px, py, 1'b0, 1'b0);
    endtask

    task automatic probe(input int px, input int py);
        step(px, py, 1'b0, 1'b0);
        step(px, py, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(5, 5, 1'b0, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  f;
        int  b;
        int  o;
        bit  dropped;
        int  r;
        int  x;
        int  y;

        rst = 1'b1; blink_req = 1'b0; ax = 8'd5; ay = 8'd5;
        tick_cnt = 0;
        vt[0]  = '{x: 40, y: 55,  exp: FG};
        vt[1]  = '{x: 10, y: 10,  exp: BG};
        vt[2]  = '{x: 60, y: 101, exp: FG};
        vt[3]  = '{x: 200, y: 10, exp: BG};
        vt[4]  = '{x: 36, y: 50,  exp: FG};
        vt[5]  = '{x: 35, y: 50,  exp: BG};
        vt[6]  = '{x: 51, y: 65,  exp: FG};
        vt[7]  = '{x: 52, y: 65,  exp: BG};
        vt[8]  = '{x: 80, y: 49,  exp: BG};
        vt[9]  = '{x: 95, y: 66,  exp: BG};
        vt[10] = '{x: 95, y: 50,  exp: FG};
        vt[11] = '{x: 85, y: 103, exp: FG};
        vt[12] = '{x: 86, y: 103, exp: BG};
        vt[13] = '{x: 46, y: 99,  exp: BG};

        // reset state
        do_reset();
        check("rst_ram_data",   int'(ram_data),   int'(BG));
        check("rst_frame_tick", int'(frame_tick), 0);
        check("rst_phase",      int'(phase),      0);
        check("rst_busy",       int'(busy),       0);

        // pixel colours, eyes open
        for (int i = 0; i < 14; i++) begin
            probe(vt[i].x, vt[i].y);
            check("pixel_vec", int'(last_data), int'(vt[i].exp));
        end

        // frame ticks: origin held for several cycles gives one tick each
        tick_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) step(0, 0, 1'b0, 1'b0);
            probe(10, 10);
        end
        check("tick_count", tick_cnt, 3);
        check("phase_after_ticks", int'(phase), 0);

        // requested blink
        do_reset();
        for (int i = 1; i <= 4; i++) frame(10, 10, 1'b0);
        frame(10, 10, 1'b1);
        check("req_still_open", int'(phase), 0);
        frame(10, 10, 1'b0);
        check("req_closing", int'(phase), 1);
        for (int i = 7; i <= 14; i++) frame(10, 10, 1'b0);
        check("req_closed", int'(phase), 2);
        probe(40, 51);
        check("closed_row51", int'(last_data), int'(BG));
        probe(40, 57);
        check("closed_row57", int'(last_data), int'(FG));
        for (int i = 15; i <= 23; i++) frame(10, 10, 1'b0);
        check("req_opening", int'(phase), 3);
        frame(10, 10, 1'b0);
        check("req_reopen", int'(phase), 0);

        // reset mid-blink with lid at 2
        do_reset();
        for (int i = 1; i <= 4; i++) frame(10, 10, 1'b0);
        frame(10, 10, 1'b1);
        for (int i = 6; i <= 20; i++) frame(10, 10, 1'b0);
        check("lid2_phase", int'(phase), 3);
        probe(40, 54);
        check("lid2_row54", int'(last_data), int'(FG));
        probe(40, 53);
        check("lid2_row53", int'(last_data), int'(BG));
        step(40, 53, 1'b0, 1'b1);
        check("midrst_phase", int'(phase), 0);
        check("midrst_busy",  int'(busy),  0);
        frame(40, 50, 1'b0);
        check("midrst_open_row50", int'(last_data), int'(FG));

        // auto blink, then a request dropped while closed
        do_reset();
        f = 0;
        do begin
            frame(10, 10, 1'b0);
            f++;
        end while (phase == 2'd0 && f < 200);
        check("auto_start_tick", f, HOLD);
        b = 1;
        dropped = 1'b0;
        while (b < 100) begin
            frame(10, 10, 1'b0);
            if (!busy) break;
            b++;
            if (phase == 2'd2 && !dropped) begin
                step(10, 10, 1'b1, 1'b0);
                dropped = 1'b1;
            end
        end
        check("busy_frames", b, 18);
        o = 1;
        while (o < 200) begin
            frame(10, 10, 1'b0);
            if (phase != 2'd0) break;
            o++;
        end
        check("open_frames_after_drop", o, HOLD);

        // randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                for (int j = 0; j < int'($urandom_range(1, 4)); j++) step(0, 0, 1'b0, 1'b0);
            end else if (r < 13) begin
                step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, 1'b1);
            end else begin
                if ($urandom_range(0, 1) == 0) begin
                    x = $urandom_range(30, 100);
                    y = $urandom_range(45, 110);
                end else begin
                    x = $urandom_range(0, 255);
                    y = $urandom_range(0, 255);
                end
                step(x, y, ($urandom_range(0, 19) == 0), 1'b0);
                step(x, y, 1'b0, 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
